// File: rtl/frame_stream_source_pkg.sv
// Shared geometry defaults, blanking defaults and FSM state type for frame_stream_source.
package frame_stream_source_pkg;

  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;
  localparam int DEFAULT_PIXEL_SIZE   = 24;

  localparam int DEFAULT_HBLANK     = 2;
  localparam int DEFAULT_VBLANK     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBL    = 2'd2,
    VBL    = 2'd3
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_stream_source_stream_delay.sv
// stream_delay: N-stage shift register aligning control tags with frame-buffer read data.
module stream_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/frame_stream_source.sv
// Raster-order frame-buffer reader emitting en/hsync/vsync/data with blanking.
// Optional STREAM_TEST_PATTERN_EN adds pattern_sel (data = {0, y, x}, no reads).
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int HBLANK       = DEFAULT_HBLANK,
  parameter int VBLANK       = DEFAULT_VBLANK,
  parameter int PIXEL_SIZE   = DEFAULT_PIXEL_SIZE,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cont,
`ifdef STREAM_TEST_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data
);

  localparam int XW = cnt_width(FRAME_WIDTH);
  localparam int YW = cnt_width(FRAME_HEIGHT);
  localparam int BW = cnt_width((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(HBLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(VBLANK - 1);
`ifdef STREAM_TEST_PATTERN_EN
  localparam int TW = 21;
`else
  localparam int TW = 4;
`endif

  state_t                r_state, w_state_n;
  logic [XW-1:0]         r_x, w_x_n;
  logic [YW-1:0]         r_y, w_y_n;
  logic [BW-1:0]         r_bcnt, w_bcnt_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic                  w_rd, w_en_t, w_hs_t, w_vs_t, w_done_t, w_accept;
  logic [TW-1:0]         w_tag, w_dly;
  logic [PIXEL_SIZE-1:0] w_pix;
  logic                  r_en, r_hs, r_vs, r_done, r_busy;
  logic [PIXEL_SIZE-1:0] r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_bcnt  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_bcnt  <= w_bcnt_n;
      r_addr  <= w_addr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_bcnt_n  = r_bcnt;
    w_addr_n  = r_addr;
    w_rd      = 1'b0;
    w_en_t    = 1'b0;
    w_hs_t    = 1'b0;
    w_vs_t    = 1'b0;
    w_done_t  = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !r_busy) begin
          w_accept  = 1'b1;
          w_state_n = ACTIVE;
          w_x_n     = '0;
          w_y_n     = '0;
          w_addr_n  = '0;
        end
      end
      ACTIVE: begin
        w_rd   = 1'b1;
        w_en_t = 1'b1;
        if (r_x == X_LAST) begin
          w_x_n    = '0;
          w_bcnt_n = '0;
          // Address wraps on the last pixel so it never passes W*H-1.
          if (r_y == Y_LAST) begin
            w_state_n = VBL;
            w_addr_n  = '0;
          end else begin
            w_state_n = HBL;
            w_addr_n  = r_addr + ADDR_WIDTH'(1);
          end
        end else begin
          w_x_n    = r_x + XW'(1);
          w_addr_n = r_addr + ADDR_WIDTH'(1);
        end
      end
      HBL: begin
        w_hs_t = (r_bcnt == '0);
        if (r_bcnt == HB_LAST) begin
          w_state_n = ACTIVE;
          w_bcnt_n  = '0;
          w_y_n     = r_y + YW'(1);
        end else begin
          w_bcnt_n = r_bcnt + BW'(1);
        end
      end
      VBL: begin
        w_vs_t = (r_bcnt == '0);
        if (r_bcnt == VB_LAST) begin
          w_bcnt_n = '0;
          if (cont) begin
            w_state_n = ACTIVE;
            w_x_n     = '0;
            w_y_n     = '0;
            w_addr_n  = '0;
          end else begin
            w_state_n = IDLE;
            w_done_t  = 1'b1;
          end
        end else begin
          w_bcnt_n = r_bcnt + BW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

`ifdef STREAM_TEST_PATTERN_EN
  assign rd_en = w_rd & ~pattern_sel;
  assign w_tag = {pattern_sel, 8'(r_y), 8'(r_x), w_done_t, w_vs_t, w_hs_t, w_en_t};
  assign w_pix = w_dly[20] ? PIXEL_SIZE'({8'h00, w_dly[19:12], w_dly[11:4]}) : rd_data;
`else
  assign rd_en = w_rd;
  assign w_tag = {w_done_t, w_vs_t, w_hs_t, w_en_t};
  assign w_pix = rd_data;
`endif
  assign rd_addr = r_addr;

  stream_delay #(.WIDTH(TW), .DEPTH(1)) u_tag_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_tag),
    .o_q     (w_dly)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en   <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_done <= 1'b0;
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_en   <= w_dly[0];
      r_hs   <= w_dly[1];
      r_vs   <= w_dly[2];
      r_done <= w_dly[3];
      r_data <= w_dly[0] ? w_pix : '0;
      // busy holds until the delayed done pulse has been presented.
      if (r_done)        r_busy <= 1'b0;
      else if (w_accept) r_busy <= 1'b1;
    end
  end

  assign en    = r_en;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign done  = r_done;
  assign data  = r_data;
  assign busy  = r_busy;

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Produces the pixel stream protocol consumed by the detection pipeline's stream input: en, hsync, vsync and a PIXEL_SIZE data bus.
- Reads one frame from a synchronous frame-buffer memory in raster order.
- Inserts horizontal and vertical blanking around the active pixels.
- Drives the pipeline in simulation and on hardware in place of a camera front end.

Parameters:
- FRAME_WIDTH, `FRAME_WIDTH: active pixels per row (>=2).
- FRAME_HEIGHT, `FRAME_HEIGHT: active rows per frame (>=2).
- HBLANK, 2: cycles between rows, including the hsync cycle (>=1).
- VBLANK, 4: cycles after the last row, including the vsync cycle (>=1).
- PIXEL_SIZE, `PIXEL_SIZE: pixel width (24, RGB, R in [7:0]).
- ADDR_WIDTH, 20: frame-buffer address width; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin streaming; sampled only in IDLE
- cont  in  1  loop frames continuously; sampled at each frame end
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse when the final frame's last blanking cycle has been emitted
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_WIDTH  read address, linear y*FRAME_WIDTH+x
- rd_data  in  PIXEL_SIZE  read data, valid exactly 1 cycle after rd_en
- en  out  1  data carries a valid pixel this cycle
- hsync  out  1  one-cycle row-end pulse (en low)
- vsync  out  1  one-cycle frame-end pulse (en low; replaces hsync on the last row)
- data  out  PIXEL_SIZE  pixel value; 0 when en is low

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-frame aborts immediately; there is no partial-frame recovery.
- States:
  - IDLE: start=1 -> ACTIVE, x=y=0, addr=0.
  - ACTIVE: issue rd_en=1 each cycle, x++ and addr++. At x==FRAME_WIDTH-1, go to HBL, or to VBL if y==FRAME_HEIGHT-1.
  - HBL: HBLANK cycles; the first cycle tags hsync. Then go to ACTIVE with x=0 and y++.
  - VBL: VBLANK cycles; the first cycle tags vsync. On the last cycle: cont=1 -> ACTIVE with x=y=0 and addr=0; otherwise -> IDLE and tag done.
- Output pipeline: control tags (en, hsync, vsync, done) are generated in the issue stage, delayed 1 cycle to align with rd_data, then registered with data. Latency from rd_en to en/data is 2 cycles. hsync, vsync and done use the same 2-cycle delay.
- busy stays high until the delayed done pulse emerges. start is ignored while busy.
- Per frame, output sequence: per row, FRAME_WIDTH en cycles, then hsync plus HBLANK-1 idle cycles. The last row ends with vsync plus VBLANK-1 idle cycles instead.
- Frame length: FRAME_HEIGHT*FRAME_WIDTH + (FRAME_HEIGHT-1)*HBLANK + VBLANK cycles.
- en, hsync and vsync are mutually exclusive every cycle.
- rd_addr wraps to 0 at frame end. It never exceeds FRAME_WIDTH*FRAME_HEIGHT-1.
- Simultaneous start and frame end: start is ignored; only cont decides.
- cont drop mid-frame: the current frame completes, then the block stops.

Optional Feature:
- Macro: STREAM_TEST_PATTERN_EN.
- Defined: a new input pattern_sel (1 bit) is added. When pattern_sel=1, data = {8'h00, y[7:0], x[7:0]} (B=0, G=y, R=x) and rd_en is held 0. Timing is unchanged.
- Undefined: the port is absent and data always comes from rd_data.

Decomposition:
- FRAME_WIDTH, FRAME_HEIGHT, PIXEL_SIZE and WORD_SIZE stay in global.vh.
- Add DEFAULT_HBLANK and DEFAULT_VBLANK there, plus state encodings (IDLE=0, ACTIVE=1, HBL=2, VBL=3).
- One sub-module: stream_delay, a parameterised N-stage shift register used to align the control tags with memory data.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=3, HBLANK=2, VBLANK=3; memory word = address):
- start pulse, cont=0 -> first en 3 cycles after start. Data sequence 0..11, four per row. hsync after pixels 3 and 7, vsync after pixel 11. Frame is 12+4+3=19 cycles. done pulses once, busy drops the cycle after done.
- cont=1 held -> the second frame begins right after VBL with data 0 again. rd_addr never exceeds 11. No cycle has two of en/hsync/vsync set.
- start asserted while busy -> no restart, sequence unchanged. cont cleared during frame 2 -> frame 2 completes, done, IDLE.
- reset_n low at the 6th pixel -> en, hsync, vsync, rd_en, busy and data are 0 immediately (asynchronous). A new start after release begins again at address 0.
- STREAM_TEST_PATTERN_EN defined, pattern_sel=1 -> rd_en stays 0. The pixel at x=2, y=1 has data 24'h000102.
- Feed the output into the pipeline top -> its x/y counters match at every en cycle (row 1 pixel 0 gives x=0, y=1).
